// File: rtl/mod_vga_nes_scaler_if.sv
// Bus bundle between the NES PPU pixel stream, the VGA encoder and mod_vga_nes_scaler.
// The scaler takes the slave modport; the upstream/downstream side takes the master modport.
interface mod_vga_nes_scaler_if;
    logic       in_pix_valid;
    logic [5:0] in_pix_idx;
    logic       in_pix_sof;
    logic       out_pix_ready;
    logic [9:0] in_vga_next_x;
    logic [9:0] in_vga_next_y;
    logic       in_vga_active;
    logic [7:0] out_vga_r;
    logic [7:0] out_vga_g;
    logic [7:0] out_vga_b;
    logic       out_underrun;

    modport master (
        output in_pix_valid, in_pix_idx, in_pix_sof,
        output in_vga_next_x, in_vga_next_y, in_vga_active,
        input  out_pix_ready, out_vga_r, out_vga_g, out_vga_b, out_underrun
    );

    modport slave (
        input  in_pix_valid, in_pix_idx, in_pix_sof,
        input  in_vga_next_x, in_vga_next_y, in_vga_active,
        output out_pix_ready, out_vga_r, out_vga_g, out_vga_b, out_underrun
    );
endinterface

// File: rtl/mod_vga_nes_scaler.sv
// NES 256x240 to VGA 2x scaler: ping-pong line buffers, palette ROM, two-stage read pipeline.
// Optional CRT scanline dimming on even VGA lines with MOD_VGA_NES_SCALER_SCANLINE_EN.
module mod_vga_nes_scaler #(
    parameter int unsigned H_OFFSET = 64,
    parameter int unsigned H_WIDTH  = 512
) (
    input  logic                     in_clk_25_175_mhz,
    input  logic                     in_rst,
    mod_vga_nes_scaler_if.slave      bus
);
    localparam int unsigned XW    = 10;
    localparam int unsigned IW    = 6;
    localparam int unsigned AW    = 8;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned CW    = 8;
    localparam int unsigned X_LAST = 639;

    localparam logic [XW-1:0] H_START = XW'(H_OFFSET);
    localparam logic [XW:0]   H_END   = (XW+1)'(H_OFFSET + H_WIDTH);

    logic [IW-1:0] line_buf0 [DEPTH];
    logic [IW-1:0] line_buf1 [DEPTH];

    logic          wr_sel;
    logic [AW-1:0] wr_ptr;
    logic          wr_full;
    logic          rd_valid;
    logic          underrun_q;

    logic          pix_ready_c;
    logic          beat;
    logic          swap_evt;
    logic [AW-1:0] wr_addr;
    logic          in_cols;
    logic [AW-1:0] rd_addr;
    logic [IW-1:0] rd_data;

    logic          s1_vis;
    logic [IW-1:0] s1_idx;
`ifdef MOD_VGA_NES_SCALER_SCANLINE_EN
    logic          s1_y0;
`endif
    logic [3*CW-1:0] rgb_next;
    logic [3*CW-1:0] rgb_q;

    function automatic logic [3*CW-1:0] nes_palette(input logic [IW-1:0] idx);
        logic [3*CW-1:0] c;
        c = '0;
        case (idx)
            6'h00: c = 24'h7C7C7C; 6'h01: c = 24'h0000FC; 6'h02: c = 24'h0000BC; 6'h03: c = 24'h4428BC;
            6'h04: c = 24'h940084; 6'h05: c = 24'hA80020; 6'h06: c = 24'hA81000; 6'h07: c = 24'h881400;
            6'h08: c = 24'h503000; 6'h09: c = 24'h007800; 6'h0A: c = 24'h006800; 6'h0B: c = 24'h005800;
            6'h0C: c = 24'h004058; 6'h0D: c = 24'h000000; 6'h0E: c = 24'h000000; 6'h0F: c = 24'h000000;
            6'h10: c = 24'hBCBCBC; 6'h11: c = 24'h0078F8; 6'h12: c = 24'h0058F8; 6'h13: c = 24'h6844FC;
            6'h14: c = 24'hD800CC; 6'h15: c = 24'hE40058; 6'h16: c = 24'hF83800; 6'h17: c = 24'hE45C10;
            6'h18: c = 24'hAC7C00; 6'h19: c = 24'h00B800; 6'h1A: c = 24'h00A800; 6'h1B: c = 24'h00A844;
            6'h1C: c = 24'h008888; 6'h1D: c = 24'h000000; 6'h1E: c = 24'h000000; 6'h1F: c = 24'h000000;
            6'h20: c = 24'hF8F8F8; 6'h21: c = 24'h3CBCFC; 6'h22: c = 24'h6888FC; 6'h23: c = 24'h9878F8;
            6'h24: c = 24'hF878F8; 6'h25: c = 24'hF85898; 6'h26: c = 24'hF87858; 6'h27: c = 24'hFCA044;
            6'h28: c = 24'hF8B800; 6'h29: c = 24'hB8F818; 6'h2A: c = 24'h58D854; 6'h2B: c = 24'h58F898;
            6'h2C: c = 24'h00E8D8; 6'h2D: c = 24'h787878; 6'h2E: c = 24'h000000; 6'h2F: c = 24'h000000;
            6'h30: c = 24'hFFFFFF; 6'h31: c = 24'hA4E4FC; 6'h32: c = 24'hB8B8F8; 6'h33: c = 24'hD8B8F8;
            6'h34: c = 24'hF8B8F8; 6'h35: c = 24'hF8A4C0; 6'h36: c = 24'hF0D0B0; 6'h37: c = 24'hFCE0A8;
            6'h38: c = 24'hF8D878; 6'h39: c = 24'hD8F878; 6'h3A: c = 24'hB8F8B8; 6'h3B: c = 24'hB8F8D8;
            6'h3C: c = 24'h00FCFC; 6'h3D: c = 24'hF8D8F8; 6'h3E: c = 24'h000000; 6'h3F: c = 24'h000000;
        endcase
        return c;
    endfunction

    // Write-side handshake and swap trigger at the end of each odd visible line.
    always_comb begin
        pix_ready_c = !wr_full && !in_rst;
        beat        = bus.in_pix_valid && pix_ready_c;
        swap_evt    = bus.in_vga_active && (bus.in_vga_next_x == XW'(X_LAST)) && bus.in_vga_next_y[0];
        wr_addr     = bus.in_pix_sof ? '0 : wr_ptr;
    end

    // Swap uses the pre-write wr_full, so a line completing in the swap cycle misses it.
    always_ff @(posedge in_clk_25_175_mhz) begin
        if (in_rst) begin
            wr_sel     <= 1'b0;
            wr_ptr     <= '0;
            wr_full    <= 1'b0;
            rd_valid   <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            if (swap_evt) begin
                if (wr_full) begin
                    wr_sel   <= ~wr_sel;
                    wr_full  <= 1'b0;
                    rd_valid <= 1'b1;
                end else begin
                    underrun_q <= 1'b1;
                end
            end
            if (beat) begin
                if (bus.in_pix_sof) begin
                    wr_ptr  <= AW'(1);
                    wr_full <= 1'b0;
                end else begin
                    wr_ptr <= wr_ptr + 1'b1;
                    if (wr_ptr == AW'(DEPTH - 1)) wr_full <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge in_clk_25_175_mhz) begin
        if (beat) begin
            if (wr_sel) line_buf1[wr_addr] <= bus.in_pix_idx;
            else        line_buf0[wr_addr] <= bus.in_pix_idx;
        end
    end

    // Stage 1 address: each NES pixel covers two VGA columns.
    always_comb begin
        in_cols = (bus.in_vga_next_x >= H_START) && ({1'b0, bus.in_vga_next_x} < H_END);
        rd_addr = in_cols ? AW'((bus.in_vga_next_x - H_START) >> 1) : '0;
        rd_data = wr_sel ? line_buf0[rd_addr] : line_buf1[rd_addr];
    end

    always_ff @(posedge in_clk_25_175_mhz) begin
        if (in_rst) begin
            s1_vis <= 1'b0;
            s1_idx <= '0;
`ifdef MOD_VGA_NES_SCALER_SCANLINE_EN
            s1_y0  <= 1'b0;
`endif
        end else begin
            s1_vis <= bus.in_vga_active && in_cols && rd_valid;
            s1_idx <= rd_data;
`ifdef MOD_VGA_NES_SCALER_SCANLINE_EN
            s1_y0  <= bus.in_vga_next_y[0];
`endif
        end
    end

    // Stage 2: palette lookup, optional scanline dimming.
    always_comb begin
        rgb_next = '0;
        if (s1_vis) rgb_next = nes_palette(s1_idx);
`ifdef MOD_VGA_NES_SCALER_SCANLINE_EN
        if (!s1_y0) begin
            rgb_next = {1'b0, rgb_next[23:17], 1'b0, rgb_next[15:9], 1'b0, rgb_next[7:1]};
        end
`else
`endif
    end

    always_ff @(posedge in_clk_25_175_mhz) begin
        if (in_rst) rgb_q <= '0;
        else        rgb_q <= rgb_next;
    end

    assign bus.out_pix_ready = pix_ready_c;
    assign bus.out_vga_r     = rgb_q[23:16];
    assign bus.out_vga_g     = rgb_q[15:8];
    assign bus.out_vga_b     = rgb_q[7:0];
    assign bus.out_underrun  = underrun_q;

endmodule

// File: tb/tb_mod_vga_nes_scaler.sv
// Self-checking bench for mod_vga_nes_scaler: directed line/swap scenarios with random content,
// checked against a line-level model of buffers, swaps and the 2x column mapping.
module tb_mod_vga_nes_scaler;
    localparam int H_OFF = 64;
    localparam int H_W   = 512;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    mod_vga_nes_scaler_if bus();

    mod_vga_nes_scaler #(.H_OFFSET(H_OFF), .H_WIDTH(H_W)) dut (
        .in_clk_25_175_mhz(clk),
        .in_rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    logic [23:0] pal_tab [64] = '{
        24'h7C7C7C, 24'h0000FC, 24'h0000BC, 24'h4428BC, 24'h940084, 24'hA80020, 24'hA81000, 24'h881400,
        24'h503000, 24'h007800, 24'h006800, 24'h005800, 24'h004058, 24'h000000, 24'h000000, 24'h000000,
        24'hBCBCBC, 24'h0078F8, 24'h0058F8, 24'h6844FC, 24'hD800CC, 24'hE40058, 24'hF83800, 24'hE45C10,
        24'hAC7C00, 24'h00B800, 24'h00A800, 24'h00A844, 24'h008888, 24'h000000, 24'h000000, 24'h000000,
        24'hF8F8F8, 24'h3CBCFC, 24'h6888FC, 24'h9878F8, 24'hF878F8, 24'hF85898, 24'hF87858, 24'hFCA044,
        24'hF8B800, 24'hB8F818, 24'h58D854, 24'h58F898, 24'h00E8D8, 24'h787878, 24'h000000, 24'h000000,
        24'hFFFFFF, 24'hA4E4FC, 24'hB8B8F8, 24'hD8B8F8, 24'hF8B8F8, 24'hF8A4C0, 24'hF0D0B0, 24'hFCE0A8,
        24'hF8D878, 24'hD8F878, 24'hB8F8B8, 24'hB8F8D8, 24'h00FCFC, 24'hF8D8F8, 24'h000000, 24'h000000
    };

    // Line-level model: the line being assembled, the line on screen, and the flags.
    logic [5:0] line [256];
    logic [5:0] m_wr [256];
    logic [5:0] shown [256];
    bit         shown_valid;
    int         m_cnt;
    bit         m_full;
    bit         m_underrun;

    function automatic logic [23:0] exp_rgb(input int x, input int y, input bit active);
        logic [23:0] c;
        if (!active || !shown_valid || x < H_OFF || x >= H_OFF + H_W) return 24'h0;
        c = pal_tab[shown[(x - H_OFF) / 2]];
`ifdef MOD_VGA_NES_SCALER_SCANLINE_EN
        if (y % 2 == 0) c = {c[23:16] / 8'd2, c[15:8] / 8'd2, c[7:0] / 8'd2};
`endif
        return c;
    endfunction

    task automatic model_reset();
        shown_valid = 0; m_cnt = 0; m_full = 0; m_underrun = 0;
    endtask

    task automatic model_swap();
        if (m_full) begin
            shown = m_wr; shown_valid = 1; m_full = 0; m_cnt = 0;
        end else begin
            m_underrun = 1;
        end
    endtask

    task automatic model_beat(input logic [5:0] v, input bit sof);
        if (sof) m_cnt = 0;
        m_wr[m_cnt] = v;
        m_cnt++;
        if (m_cnt == 256) begin m_full = 1; m_cnt = 0; end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic vga_idle();
        bus.in_vga_active = 1'b0;
        bus.in_vga_next_x = '0;
        bus.in_vga_next_y = '0;
    endtask

    task automatic push(input int from, input int to, input bit sof_first);
        for (int i = from; i < to; i++) begin
            bus.in_pix_valid = 1'b1;
            bus.in_pix_idx   = line[i];
            bus.in_pix_sof   = sof_first && (i == from);
            chk($sformatf("ready_beat%0d", i), 32'(bus.out_pix_ready), 32'(!m_full));
            model_beat(line[i], sof_first && (i == from));
            tick();
        end
        bus.in_pix_valid = 1'b0;
        bus.in_pix_sof   = 1'b0;
    endtask

    task automatic do_swap();
        bus.in_vga_active = 1'b1;
        bus.in_vga_next_x = 10'd639;
        bus.in_vga_next_y = 10'd1;
        model_swap();
        tick();
        vga_idle();
    endtask

    task automatic pix(input int x, input int y, input bit active, input string tag);
        logic [23:0] e;
        e = exp_rgb(x, y, active);
        bus.in_vga_active = active;
        bus.in_vga_next_x = 10'(x);
        bus.in_vga_next_y = 10'(y);
        tick();
        vga_idle();
        tick();
        chk($sformatf("%s_x%0d_y%0d", tag, x, y),
            32'({bus.out_vga_r, bus.out_vga_g, bus.out_vga_b}), 32'(e));
    endtask

    task automatic pix_rand(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            pix(int'($urandom_range(638, 0)), int'($urandom_range(479, 0)), 1'($urandom_range(1, 0)) | (k < n / 2), tag);
        end
    endtask

    task automatic rand_line();
        for (int i = 0; i < 256; i++) line[i] = 6'($urandom);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.in_pix_valid = 1'b0;
        bus.in_pix_idx   = '0;
        bus.in_pix_sof   = 1'b0;
        vga_idle();
        model_reset();

        // Reset state.
        tick();
        chk("rst_rgb_edge0", 32'({bus.out_vga_r, bus.out_vga_g, bus.out_vga_b}), 32'h0);
        chk("rst_ready_low", 32'(bus.out_pix_ready), 32'h0);
        chk("rst_underrun", 32'(bus.out_underrun), 32'h0);
        tick();
        chk("rst_rgb_edge1", 32'({bus.out_vga_r, bus.out_vga_g, bus.out_vga_b}), 32'h0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 32'(bus.out_pix_ready), 32'h1);
        pix(100, 0, 1, "no_line_black");

        // Solid 0x16 line, borders and doubling.
        for (int i = 0; i < 256; i++) line[i] = 6'h16;
        push(0, 256, 1);
        chk("ready_falls_full", 32'(bus.out_pix_ready), 32'h0);
        do_swap();
        chk("ready_after_swap", 32'(bus.out_pix_ready), 32'h1);
        chk("no_underrun", 32'(bus.out_underrun), 32'h0);
        pix(64, 2, 1, "solid");
        pix(575, 2, 1, "solid");
        pix(63, 2, 1, "solid_left_border");
        pix(576, 2, 1, "solid_right_border");
        pix(300, 3, 1, "solid_odd");
        pix(300, 3, 0, "solid_inactive");

        // Ramp line: address mapping.
        for (int i = 0; i < 256; i++) line[i] = 6'(i);
        push(0, 256, 1);
        do_swap();
        pix(64, 4, 1, "ramp");
        pix(65, 4, 1, "ramp");
        pix(66, 4, 1, "ramp");
        pix(575, 4, 1, "ramp");

        // Partial line discarded by SOF, then random full line.
        rand_line();
        push(0, 100, 1);
        rand_line();
        push(0, 256, 1);
        do_swap();
        pix_rand(16, "rand");

        // Underrun with 200 beats: previous line repeats, then swap completes.
        rand_line();
        push(0, 200, 1);
        do_swap();
        chk("underrun_partial", 32'(bus.out_underrun), 32'(m_underrun));
        pix_rand(6, "repeat");
        push(200, 256, 0);
        chk("ready_low_refill", 32'(bus.out_pix_ready), 32'h0);
        do_swap();
        chk("ready_after_late_swap", 32'(bus.out_pix_ready), 32'h1);
        pix_rand(8, "late_swap");

        // Reset mid-line discards everything.
        rand_line();
        push(0, 50, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        pix(200, 6, 1, "post_rst_black");
        chk("post_rst_underrun", 32'(bus.out_underrun), 32'h0);

        // 256th beat coinciding with the swap event.
        rand_line();
        push(0, 256, 1);
        do_swap();
        rand_line();
        push(0, 255, 1);
        bus.in_pix_valid  = 1'b1;
        bus.in_pix_idx    = line[255];
        bus.in_pix_sof    = 1'b0;
        bus.in_vga_active = 1'b1;
        bus.in_vga_next_x = 10'd639;
        bus.in_vga_next_y = 10'd1;
        model_swap();
        model_beat(line[255], 1'b0);
        tick();
        bus.in_pix_valid = 1'b0;
        vga_idle();
        chk("coincide_underrun", 32'(bus.out_underrun), 32'(m_underrun));
        chk("coincide_ready", 32'(bus.out_pix_ready), 32'(!m_full));
        pix_rand(6, "coincide_old");
        do_swap();
        chk("coincide_ready_after", 32'(bus.out_pix_ready), 32'h1);
        pix_rand(8, "coincide_new");

        // White line on even and odd VGA lines.
        for (int i = 0; i < 256; i++) line[i] = 6'h30;
        push(0, 256, 1);
        do_swap();
        pix(100, 4, 1, "white_even");
        pix(100, 5, 1, "white_odd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
